fb_writer: RTL and testbench



---
 rtl/fb_writer_pkg.sv | 16 +
 rtl/color_converter.sv | 22 ++
 rtl/define.vh | 12 +
 rtl/fb_writer.sv | 154 +++++++++++++++
 tb/tb_fb_writer.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/fb_writer_pkg.sv
// Shared types and pixel-format constants for the framebuffer write front end.
`include "define.vh"

package fb_writer_pkg;

    localparam int FB_PIX_W  = `FB_PIX_WIDTH;
    localparam int CH_W      = FB_PIX_W / 3;
    localparam int RGB565_W  = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } fb_state_t;

endpackage

// File: rtl/color_converter.sv
// RGB565 to framebuffer pixel: keeps the top CH_W bits of each channel (truncation).
`include "define.vh"

module color_converter
    import fb_writer_pkg::*;
(
    input  logic [RGB565_W-1:0] i_rgb565,
    output logic [FB_PIX_W-1:0] o_pix
);

    logic [4:0] red;
    logic [5:0] green;
    logic [4:0] blue;
    logic       unused_low_bits;

    assign {red, green, blue} = i_rgb565;
    assign o_pix = {red[4 -: CH_W], green[5 -: CH_W], blue[4 -: CH_W]};

    // Low-order channel bits are dropped on purpose.
    assign unused_low_bits = ^{red, green, blue};

endmodule

// File: rtl/define.vh
// Frame geometry and framebuffer sizing shared by the VGA framebuffer blocks.
`ifndef FB_DEFINE_VH
`define FB_DEFINE_VH

`define FRAME_WIDTH   640
`define FRAME_HEIGHT  480
`define RESIZE_RATE   2
`define FB_PIX_WIDTH  9
`define FB_ADDR_WIDTH 18
`define FB_WORDS      ((`FRAME_WIDTH*`FRAME_HEIGHT)/(`RESIZE_RATE*`RESIZE_RATE*2))

`endif

// File: rtl/fb_writer.sv
// Framebuffer write front end: registered CPU pixel-pair stores plus a whole-frame fill engine.
`include "define.vh"

module fb_writer
    import fb_writer_pkg::*;
#(
    parameter int ADDR_WIDTH = `FB_ADDR_WIDTH,
    parameter int FB_WORDS   = `FB_WORDS
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_bus_we,
    input  logic [ADDR_WIDTH-1:0]   i_bus_addr,
    input  logic [31:0]             i_bus_wdata,
    output logic                    o_bus_ready,
    input  logic                    i_fill_start,
    input  logic [15:0]             i_fill_color,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_oob,
    output logic                    o_fb_we,
    output logic [ADDR_WIDTH-1:0]   o_fb_waddr,
    output logic [2*FB_PIX_W-1:0]   o_fb_wdata
);

    localparam int CNT_W = (FB_WORDS > 1) ? $clog2(FB_WORDS) : 1;
    localparam int IDX_W = ADDR_WIDTH - 2;
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(FB_WORDS - 1);

    fb_state_t              state_reg, state_next;
    logic [CNT_W-1:0]       count_reg, count_next;
    logic [FB_PIX_W-1:0]    fill_pix_reg, fill_pix_next;

    logic                   fb_we_reg, fb_we_next;
    logic [ADDR_WIDTH-1:0]  fb_waddr_reg, fb_waddr_next;
    logic [2*FB_PIX_W-1:0]  fb_wdata_reg, fb_wdata_next;
    logic                   done_reg, done_next;
    logic                   oob_reg, oob_next;

    logic [FB_PIX_W-1:0]    store_pix [2];
    logic [FB_PIX_W-1:0]    fill_pix_conv;
    logic [IDX_W-1:0]       store_idx;
    logic                   store_in_range;
    logic                   unused_addr_bits;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_store_conv
            color_converter u_conv (
                .i_rgb565 (i_bus_wdata[gi*16 +: 16]),
                .o_pix    (store_pix[gi])
            );
        end
    endgenerate

    color_converter u_fill_conv (
        .i_rgb565 (i_fill_color),
        .o_pix    (fill_pix_conv)
    );

    assign store_idx        = i_bus_addr[ADDR_WIDTH-1:2];
    assign store_in_range   = (32'(store_idx) < 32'(FB_WORDS));
    assign unused_addr_bits = ^i_bus_addr[1:0];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg    <= ST_IDLE;
            count_reg    <= '0;
            fill_pix_reg <= '0;
        end else begin
            state_reg    <= state_next;
            count_reg    <= count_next;
            fill_pix_reg <= fill_pix_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        count_next    = count_reg;
        fill_pix_next = fill_pix_reg;
        case (state_reg)
            ST_IDLE: begin
                if (i_fill_start) begin
                    state_next    = ST_FILL;
                    count_next    = '0;
                    fill_pix_next = fill_pix_conv;
                end
            end
            ST_FILL: begin
                // Hold at the last word so the counter never leaves the frame.
                if (count_reg == LAST_WORD) begin
                    state_next = ST_DONE;
                end else begin
                    count_next = count_reg + 1'b1;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        o_bus_ready   = (state_reg == ST_IDLE);
        o_busy        = (state_reg != ST_IDLE);
        fb_we_next    = 1'b0;
        fb_waddr_next = fb_waddr_reg;
        fb_wdata_next = fb_wdata_reg;
        done_next     = 1'b0;
        oob_next      = oob_reg;
        case (state_reg)
            ST_IDLE: begin
                if (i_bus_we) begin
                    if (store_in_range) begin
                        fb_we_next    = 1'b1;
                        fb_waddr_next = {store_idx, 2'b00};
                        fb_wdata_next = {store_pix[1], store_pix[0]};
                    end else begin
                        oob_next = 1'b1;
                    end
                end
            end
            ST_FILL: begin
                fb_we_next    = 1'b1;
                fb_waddr_next = ADDR_WIDTH'({count_reg, 2'b00});
                fb_wdata_next = {fill_pix_reg, fill_pix_reg};
                done_next     = (count_reg == LAST_WORD);
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            fb_we_reg    <= 1'b0;
            fb_waddr_reg <= '0;
            fb_wdata_reg <= '0;
            done_reg     <= 1'b0;
            oob_reg      <= 1'b0;
        end else begin
            fb_we_reg    <= fb_we_next;
            fb_waddr_reg <= fb_waddr_next;
            fb_wdata_reg <= fb_wdata_next;
            done_reg     <= done_next;
            oob_reg      <= oob_next;
        end
    end

    assign o_fb_we    = fb_we_reg;
    assign o_fb_waddr = fb_waddr_reg;
    assign o_fb_wdata = fb_wdata_reg;
    assign o_done     = done_reg;
    assign o_oob      = oob_reg;

endmodule

// File: tb/tb_fb_writer.sv
// Directed bench for fb_writer: full-size instance for stores and one full fill, small instance for corner cases.
module tb_fb_writer;

    localparam int AW      = 18;
    localparam int WORDS_A = 38400;
    localparam int WORDS_B = 1200;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        sel     = 1'b0;
    logic        rst_all = 1'b1;
    logic        d_rst   = 1'b0;
    logic        d_we    = 1'b0;
    logic        d_fill  = 1'b0;
    logic [17:0] d_addr  = '0;
    logic [31:0] d_wdata = '0;
    logic [15:0] d_color = '0;

    logic a_rst, a_we, a_fill, b_rst, b_we, b_fill;
    assign a_rst  = rst_all | (d_rst & ~sel);
    assign b_rst  = rst_all | (d_rst & sel);
    assign a_we   = d_we & ~sel;
    assign b_we   = d_we & sel;
    assign a_fill = d_fill & ~sel;
    assign b_fill = d_fill & sel;

    logic        a_ready, a_busy, a_done, a_oob, a_fb_we;
    logic [17:0] a_fb_waddr, a_fb_wdata;
    logic        b_ready, b_busy, b_done, b_oob, b_fb_we;
    logic [17:0] b_fb_waddr, b_fb_wdata;

    fb_writer #(.ADDR_WIDTH(AW), .FB_WORDS(WORDS_A)) u_dut_a (
        .i_clk(clk), .i_rst(a_rst), .i_bus_we(a_we), .i_bus_addr(d_addr),
        .i_bus_wdata(d_wdata), .o_bus_ready(a_ready), .i_fill_start(a_fill),
        .i_fill_color(d_color), .o_busy(a_busy), .o_done(a_done), .o_oob(a_oob),
        .o_fb_we(a_fb_we), .o_fb_waddr(a_fb_waddr), .o_fb_wdata(a_fb_wdata)
    );

    fb_writer #(.ADDR_WIDTH(AW), .FB_WORDS(WORDS_B)) u_dut_b (
        .i_clk(clk), .i_rst(b_rst), .i_bus_we(b_we), .i_bus_addr(d_addr),
        .i_bus_wdata(d_wdata), .o_bus_ready(b_ready), .i_fill_start(b_fill),
        .i_fill_color(d_color), .o_busy(b_busy), .o_done(b_done), .o_oob(b_oob),
        .o_fb_we(b_fb_we), .o_fb_waddr(b_fb_waddr), .o_fb_wdata(b_fb_wdata)
    );

    logic        s_ready, s_busy, s_done, s_fb_we;
    logic [17:0] s_waddr, s_wdata;
    assign s_ready = sel ? b_ready    : a_ready;
    assign s_busy  = sel ? b_busy     : a_busy;
    assign s_done  = sel ? b_done     : a_done;
    assign s_fb_we = sel ? b_fb_we    : a_fb_we;
    assign s_waddr = sel ? b_fb_waddr : a_fb_waddr;
    assign s_wdata = sel ? b_fb_wdata : a_fb_wdata;

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    typedef struct {
        logic [17:0] addr;
        logic [31:0] wdata;
        logic        exp_we;
        logic [17:0] exp_waddr;
        logic [17:0] exp_wdata;
        logic        exp_oob;
    } vec_t;

    vec_t vecs[8];

    task automatic run_fill(input logic [15:0] color, input logic [8:0] pix, input int words,
                            input bit with_store, input bit restart, input int rst_at, input string tag);
        int cyc, fills, stores, dones, done_bad, addr_bad, data_bad, first_fill, nw, nd;
        bit did_rst;
        logic [17:0] pair;
        pair = {pix, pix};
        cyc = 0; fills = 0; stores = 0; dones = 0; done_bad = 0;
        addr_bad = 0; data_bad = 0; first_fill = -1; did_rst = 0;
        d_fill  = 1'b1;
        d_color = color;
        if (with_store) begin
            d_we    = 1'b1;
            d_addr  = 18'h8;
            d_wdata = 32'hF800_07E0;
        end
        @(negedge clk);
        d_fill  = 1'b0;
        d_we    = 1'b0;
        d_color = 16'h0;
        while (cyc < words + 100) begin
            if (s_ready) break;
            if (s_fb_we) begin
                if (with_store && cyc == 0) begin
                    stores++;
                    check({tag, "_store_addr"}, 32'(s_waddr), 32'h8);
                    check({tag, "_store_data"}, 32'(s_wdata), 32'({9'h1C0, 9'h038}));
                end else begin
                    if (first_fill < 0) first_fill = cyc;
                    if (s_waddr !== 18'(fills * 4)) addr_bad++;
                    if (s_wdata !== pair) data_bad++;
                    fills++;
                end
            end
            if (s_done) begin
                dones++;
                if (!(s_fb_we && fills == words)) done_bad++;
            end
            if (rst_at >= 0 && s_fb_we && fills == rst_at + 1) begin
                d_rst   = 1'b1;
                did_rst = 1'b1;
                break;
            end
            if (restart && cyc == 500) begin
                d_fill  = 1'b1;
                d_color = 16'hF800;
            end else begin
                d_fill  = 1'b0;
                d_color = 16'h0;
            end
            @(negedge clk);
            cyc++;
        end
        d_fill = 1'b0;
        if (rst_at >= 0) begin
            check({tag, "_rst_reached"}, 32'(did_rst), 32'd1);
            @(negedge clk);
            d_rst = 1'b0;
            check({tag, "_rst_we"},    32'(s_fb_we), 32'd0);
            check({tag, "_rst_ready"}, 32'(s_ready), 32'd1);
            check({tag, "_rst_busy"},  32'(s_busy),  32'd0);
            check({tag, "_rst_done"},  32'(s_done),  32'd0);
            nw = 0; nd = 0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (s_fb_we) nw++;
                if (s_done) nd++;
            end
            check({tag, "_post_rst_writes"}, 32'(nw), 32'd0);
            check({tag, "_post_rst_dones"},  32'(nd), 32'd0);
            return;
        end
        check({tag, "_busy_cycles"}, 32'(cyc),        32'(words + 1));
        check({tag, "_fill_writes"}, 32'(fills),      32'(words));
        check({tag, "_total_writes"}, 32'(fills + stores), 32'(words + (with_store ? 1 : 0)));
        check({tag, "_first_fill"},  32'(first_fill), 32'd1);
        check({tag, "_done_pulses"}, 32'(dones),      32'd1);
        check({tag, "_done_align"},  32'(done_bad),   32'd0);
        check({tag, "_addr_errs"},   32'(addr_bad),   32'd0);
        check({tag, "_data_errs"},   32'(data_bad),   32'd0);
        check({tag, "_end_busy"},    32'(s_busy),     32'd0);
        check({tag, "_end_we"},      32'(s_fb_we),    32'd0);
    endtask

    initial begin
        vecs[0] = '{18'h00010, 32'hF800_07E0, 1'b1, 18'h00010, {9'h1C0, 9'h038}, 1'b0};
        vecs[1] = '{18'h12C03, 32'h001F_FFFF, 1'b1, 18'h12C00, {9'h007, 9'h1FF}, 1'b0};
        vecs[2] = '{18'h00000, 32'h0000_0000, 1'b1, 18'h00000, {9'h000, 9'h000}, 1'b0};
        vecs[3] = '{18'h257FC, 32'h07E0_001F, 1'b1, 18'h257FC, {9'h038, 9'h007}, 1'b0};
        vecs[4] = '{18'h12345, 32'h1234_5678, 1'b1, 18'h12344, {9'h015, 9'h0B6}, 1'b0};
        vecs[5] = '{18'h25800, 32'hAAAA_5555, 1'b0, 18'h00000, 18'h0,            1'b1};
        vecs[6] = '{18'h00004, 32'h0000_FFFF, 1'b1, 18'h00004, {9'h000, 9'h1FF}, 1'b1};
        vecs[7] = '{18'h3FFFF, 32'h1234_5678, 1'b0, 18'h00000, 18'h0,            1'b1};

        repeat (3) @(negedge clk);
        rst_all = 1'b0;
        check("rst_we",    32'(a_fb_we),    32'd0);
        check("rst_waddr", 32'(a_fb_waddr), 32'd0);
        check("rst_wdata", 32'(a_fb_wdata), 32'd0);
        check("rst_done",  32'(a_done),     32'd0);
        check("rst_oob",   32'(a_oob),      32'd0);
        check("rst_busy",  32'(a_busy),     32'd0);
        check("rst_ready", 32'(a_ready),    32'd1);
        check("rst_ready_b", 32'(b_ready),  32'd1);

        // Back-to-back stores: each result is checked while the next store is presented.
        for (int i = 0; i < 8; i++) begin
            d_we    = 1'b1;
            d_addr  = vecs[i].addr;
            d_wdata = vecs[i].wdata;
            @(negedge clk);
            check($sformatf("vec%0d_we", i),  32'(a_fb_we), 32'(vecs[i].exp_we));
            check($sformatf("vec%0d_oob", i), 32'(a_oob),   32'(vecs[i].exp_oob));
            if (vecs[i].exp_we) begin
                check($sformatf("vec%0d_waddr", i), 32'(a_fb_waddr), 32'(vecs[i].exp_waddr));
                check($sformatf("vec%0d_wdata", i), 32'(a_fb_wdata), 32'(vecs[i].exp_wdata));
            end
        end
        d_we = 1'b0;
        @(negedge clk);
        check("trail_we",  32'(a_fb_we), 32'd0);
        check("trail_oob", 32'(a_oob),   32'd1);
        d_rst = 1'b1;
        @(negedge clk);
        d_rst = 1'b0;
        check("oob_cleared", 32'(a_oob), 32'd0);

        run_fill(16'h001F, 9'h007, WORDS_A, 1'b0, 1'b1, -1, "fillA");

        sel = 1'b1;
        @(negedge clk);
        run_fill(16'h07E0, 9'h038, WORDS_B, 1'b1, 1'b0, -1, "fillB_store");
        run_fill(16'hF800, 9'h1C0, WORDS_B, 1'b0, 1'b0, 1000, "fillB_rst");

        d_we    = 1'b1;
        d_addr  = 18'h20;
        d_wdata = 32'h001F_F800;
        @(negedge clk);
        d_we = 1'b0;
        check("post_rst_store_we",    32'(b_fb_we),    32'd1);
        check("post_rst_store_waddr", 32'(b_fb_waddr), 32'h20);
        check("post_rst_store_wdata", 32'(b_fb_wdata), 32'({9'h007, 9'h1C0}));
        @(negedge clk);
        check("post_rst_store_we_off", 32'(b_fb_we), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
